source_pool_mgr: RTL and testbench
==================================

# source_pool_mgr

Responder end of the source-apply path: accepts packed {len, id} apply requests and deducts len from a shared source pool. It returns the resources when the WQE retires (release by id) and publishes the live pool level as `source_available` back to the apply stage. Because the apply stage checks availability only at enqueue, this block is the authoritative admission point. It re-checks every request and never lets the pool go negative.

## Interface
- `WQE_INDEX_WIDTH`, 10, WQE id width; the id space holds 2^WQE_INDEX_WIDTH entries.
- `WQE_SOURCE_LENGTH`, 11, width of len and of the pool counter.
- `SOURCE_TOTAL`, 1024, pool size after reset. Must be ≤ 2^WQE_SOURCE_LENGTH−1; elaboration error otherwise.

Ports:
- `sys_clk`  in  1  clock
- `sys_rst`  in  1  reset; asynchronous, active-high
- `s_axis_Papply_valid`  in  1  apply request valid
- `s_axis_Papply_id_len`  in  WQE_INDEX_WIDTH+WQE_SOURCE_LENGTH  {len[MSBs], id[LSBs]}
- `s_axis_Papply_ready`  out  1  apply accepted when valid&&ready
- `s_axis_release_valid`  in  1  WQE retired
- `s_axis_release_id`  in  WQE_INDEX_WIDTH  id being retired
- `s_axis_release_ready`  out  1  constant 1 outside reset
- `m_axis_grant_valid`  out  1  granted allocation
- `m_axis_grant_id`  out  WQE_INDEX_WIDTH  granted id
- `m_axis_grant_len`  out  WQE_SOURCE_LENGTH  granted len
- `m_axis_grant_ready`  in  1  downstream accept
- `source_available`  out  WQE_SOURCE_LENGTH  current free pool, registered
- `outstanding_cnt`  out  WQE_INDEX_WIDTH+1  ids currently allocated
- `err_dup_apply`  out  1  one-cycle pulse: apply for an id already outstanding
- `err_bad_release`  out  1  one-cycle pulse: release of an id not outstanding, or pool overflow

## Operation
- State:
  - `avail` register, reset to SOURCE_TOTAL.
  - Outstanding bitmap, one bit per id, reset to 0.
  - Length table, one len per id, synchronous-read RAM, not reset.
  - Grant output register.
- `s_axis_Papply_ready` is combinational: `!sys_rst && (!m_axis_grant_valid || m_axis_grant_ready) && len <= avail`.
  - It may depend on the presented len. The upstream holds data stable while valid.
- On apply accept with the id not outstanding:
  - Set the bitmap bit and write len to the table.
  - Subtract len from avail.
  - Load the grant register with {id, len}; valid=1.
- On apply accept with the id already outstanding:
  - Consume the request and pulse `err_dup_apply`.
  - No deduction, no grant, no table write.
- len = 0 is legal: it is tracked as outstanding and granted; avail is unchanged.
- Release is a 2-stage pipeline, never stalling.
  - S0 (accept): if the bit is set, clear it and issue a table read. Otherwise pulse `err_bad_release` and drop.
  - S1: add the read len to avail.
- Pool update each cycle: `avail_next = avail − apply_len(accepted, non-dup) + s1_len(valid)`.
  - Compute in WQE_SOURCE_LENGTH+1 bits.
  - If the result exceeds SOURCE_TOTAL, saturate to SOURCE_TOTAL and pulse `err_bad_release`.
  - Underflow is impossible by the admission check.
- Apply and release for the same id in the same cycle: the apply sees the id as still outstanding, so it is treated as a dup (`err_dup_apply`); the release proceeds normally.
- Apply for an id released in the previous cycle is legal. The table read completes at the edge before the new write.
- `outstanding_cnt` counts +1 on a non-dup apply and −1 on a valid S0 release; both in one cycle leaves it unchanged.

## Timing
- Reset values:
  - `s_axis_Papply_ready`=0, `s_axis_release_ready`=0.
  - `m_axis_grant_valid`=0, `m_axis_grant_id`/`m_axis_grant_len`=0.
  - `source_available`=SOURCE_TOTAL, `outstanding_cnt`=0.
  - Both err outputs 0.
  - Reset mid-operation discards in-flight releases and the pending grant.
- Apply accepted in cycle N:
  - Grant valid from N+1.
  - `source_available` reduced from N+1.
- Release accepted in cycle N: `source_available` increased from N+2.
- Grant valid and data hold until `m_axis_grant_ready`.
  - Back-to-back grants are possible when ready is high every cycle (1 grant/cycle).
- Error pulses appear at N+1 relative to the offending accept (S1 for overflow).

## Structure
- Package `source_pkg`:
  - Width localparams.
  - id_len pack/unpack functions (len in upper bits, id in lower bits, matching the apply stage).
  - SOURCE_TOTAL range check.
- Sub-module `source_len_table`: simple dual-port RAM, 2^WQE_INDEX_WIDTH × WQE_SOURCE_LENGTH, 1-cycle synchronous read, write-first irrelevant by construction.
- Bitmap and counters stay in the top level.

## Test plan
- Reset, then apply {len=100, id=5}: grant {5,100} at N+1; `source_available` 1024→924; `outstanding_cnt`=1.
- Release id=5 at cycle M: `source_available`=1024 at M+2; `outstanding_cnt`=0; no error.
- Pool exhaustion:
  - Apply len=1000 then len=100: second apply sees ready=0.
  - Release the first: ready rises at M+2 and the second is granted.
- Dup and same-cycle cases:
  - Apply id=7 twice: second apply gives `err_dup_apply` pulse, no grant, avail unchanged.
  - Simultaneous apply/release of id 7: release succeeds, apply flagged dup.
- Release id=9, never allocated: `err_bad_release` pulse; avail and count unchanged.
- Backpressure and reset:
  - Hold `m_axis_grant_ready`=0 with 3 queued applies: grant data stable, apply ready=0, avail deducted once.
  - Assert `sys_rst` mid-stream: all outputs return to their reset values.

Source files
------------

// File: rtl/source_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : source_pkg
//  Purpose  : Shared widths and helpers for the source-apply responder.
//             - default id / len widths and pool size
//             - pack/unpack of the {len, id} apply word (len in the upper
//               bits, id in the lower bits, matching the apply stage)
//             - range check for the configured pool size
//  Revision : 1.0  initial release
// ============================================================================
package source_pkg;

    localparam int IDX_W_DEFAULT      = 10;
    localparam int LEN_W_DEFAULT      = 11;
    localparam int SOURCE_TOTAL_DEF   = 1024;
    localparam int ID_LEN_W_DEFAULT   = IDX_W_DEFAULT + LEN_W_DEFAULT;

    // Pack an apply request at the default widths.
    function automatic logic [ID_LEN_W_DEFAULT-1:0] pack_id_len(
        input logic [IDX_W_DEFAULT-1:0] id,
        input logic [LEN_W_DEFAULT-1:0] len
    );
        return {len, id};
    endfunction

    function automatic logic [IDX_W_DEFAULT-1:0] id_of(
        input logic [ID_LEN_W_DEFAULT-1:0] id_len
    );
        return id_len[IDX_W_DEFAULT-1:0];
    endfunction

    function automatic logic [LEN_W_DEFAULT-1:0] len_of(
        input logic [ID_LEN_W_DEFAULT-1:0] id_len
    );
        return id_len[ID_LEN_W_DEFAULT-1:IDX_W_DEFAULT];
    endfunction

    // The pool counter is len_width bits wide, so the full pool must be
    // representable in it.
    function automatic bit source_total_ok(input longint total, input int len_width);
        return (total >= 0) && (total <= ((longint'(1) << len_width) - 1));
    endfunction

endpackage : source_pkg
`default_nettype wire

// File: rtl/source_len_table.sv
`default_nettype none
// ============================================================================
//  Module   : source_len_table
//  Purpose  : Simple dual-port RAM holding the granted len of every
//             outstanding id. One write port, one read port with a
//             single-cycle registered read. Contents are not reset.
//  Ports    : clk              clock
//             wr_en/addr/data  write port (apply side)
//             rd_en/addr       read request (release side)
//             rd_data          read data, valid the cycle after rd_en
//  Revision : 1.0  initial release
// ============================================================================
module source_len_table #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read and write never target the same live entry in one cycle: a
    // write only happens for an id that is not outstanding, a read only
    // for an id that is. Read-during-write ordering therefore never matters.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : source_len_table
`default_nettype wire

// File: rtl/source_pool_mgr.sv
`default_nettype none
// ============================================================================
//  Module   : source_pool_mgr
//  Purpose  : Authoritative admission point for the shared source pool.
//             Apply requests {len, id} are re-checked against the live pool
//             and deducted on grant; retiring ids return their len through
//             a two-stage release pipeline (bitmap check, then table read).
//  Ports    : sys_clk / sys_rst            clock, async active-high reset
//             s_axis_Papply_*              apply request (valid/ready)
//             s_axis_release_*             release by id (never stalls)
//             m_axis_grant_*               granted {id, len} (valid/ready)
//             source_available             registered free pool level
//             outstanding_cnt              number of ids allocated
//             err_dup_apply                pulse: apply of outstanding id
//             err_bad_release              pulse: release of idle id or
//                                          pool overflow
//  Revision : 1.0  initial release
// ============================================================================
module source_pool_mgr
    import source_pkg::*;
#(
    parameter int WQE_INDEX_WIDTH   = IDX_W_DEFAULT,
    parameter int WQE_SOURCE_LENGTH = LEN_W_DEFAULT,
    parameter int SOURCE_TOTAL      = SOURCE_TOTAL_DEF
) (
    input  logic                                       sys_clk,
    input  logic                                       sys_rst,

    input  logic                                       s_axis_Papply_valid,
    input  logic [WQE_INDEX_WIDTH+WQE_SOURCE_LENGTH-1:0] s_axis_Papply_id_len,
    output logic                                       s_axis_Papply_ready,

    input  logic                                       s_axis_release_valid,
    input  logic [WQE_INDEX_WIDTH-1:0]                 s_axis_release_id,
    output logic                                       s_axis_release_ready,

    output logic                                       m_axis_grant_valid,
    output logic [WQE_INDEX_WIDTH-1:0]                 m_axis_grant_id,
    output logic [WQE_SOURCE_LENGTH-1:0]               m_axis_grant_len,
    input  logic                                       m_axis_grant_ready,

    output logic [WQE_SOURCE_LENGTH-1:0]               source_available,
    output logic [WQE_INDEX_WIDTH:0]                   outstanding_cnt,
    output logic                                       err_dup_apply,
    output logic                                       err_bad_release
);

    localparam int IW    = WQE_INDEX_WIDTH;
    localparam int LW    = WQE_SOURCE_LENGTH;
    localparam int DEPTH = 1 << IW;

    localparam logic [LW-1:0] TOTAL_L = LW'(SOURCE_TOTAL);
    localparam logic [LW:0]   TOTAL_W = (LW+1)'(SOURCE_TOTAL);

    generate
        if (!source_total_ok(SOURCE_TOTAL, WQE_SOURCE_LENGTH)) begin : g_total_check
            $error("SOURCE_TOTAL does not fit in WQE_SOURCE_LENGTH bits");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [LW-1:0]    avail;
    logic [DEPTH-1:0] bitmap;
    logic [IW:0]      cnt;
    logic             s1_valid;
    logic [LW-1:0]    s1_len;
    logic             grant_valid;
    logic [IW-1:0]    grant_id;
    logic [LW-1:0]    grant_len;
    logic             dup_pulse;
    logic             bad_pulse;

    // ------------------------------------------------------------------
    // Apply path
    // ------------------------------------------------------------------
    logic [IW-1:0] apply_id;
    logic [LW-1:0] apply_len;
    logic          apply_ready;
    logic          apply_fire;
    logic          apply_dup;
    logic          apply_ok;

    assign apply_id  = s_axis_Papply_id_len[IW-1:0];
    assign apply_len = s_axis_Papply_id_len[IW+LW-1:IW];

    // Ready looks at the presented len so an oversized request simply waits
    // until enough of the pool has been returned.
    assign apply_ready = !sys_rst
                       && (!grant_valid || m_axis_grant_ready)
                       && (apply_len <= avail);

    assign apply_fire = s_axis_Papply_valid && apply_ready;
    // The bitmap is sampled before any same-cycle release clears it, so an
    // apply racing a release of the same id is treated as a duplicate.
    assign apply_dup  = bitmap[apply_id];
    assign apply_ok   = apply_fire && !apply_dup;

    // ------------------------------------------------------------------
    // Release path, stage 0
    // ------------------------------------------------------------------
    logic rel_fire;
    logic rel_hit;
    logic rel_miss;

    assign rel_fire = s_axis_release_valid && !sys_rst;
    assign rel_hit  = rel_fire && bitmap[s_axis_release_id];
    assign rel_miss = rel_fire && !bitmap[s_axis_release_id];

    source_len_table #(
        .ADDR_W (IW),
        .DATA_W (LW)
    ) u_len_table (
        .clk     (sys_clk),
        .wr_en   (apply_ok),
        .wr_addr (apply_id),
        .wr_data (apply_len),
        .rd_en   (rel_hit),
        .rd_addr (s_axis_release_id),
        .rd_data (s1_len)
    );

    // ------------------------------------------------------------------
    // Pool arithmetic: add the returning len before subtracting the new
    // one so the extra-bit intermediate never goes negative.
    // ------------------------------------------------------------------
    logic [LW:0]   avail_sum;
    logic          avail_ovf;
    logic [LW-1:0] avail_next;

    always_comb begin
        avail_sum = {1'b0, avail};
        if (s1_valid) begin
            avail_sum = avail_sum + {1'b0, s1_len};
        end
        if (apply_ok) begin
            avail_sum = avail_sum - {1'b0, apply_len};
        end
        avail_ovf  = (avail_sum > TOTAL_W);
        avail_next = avail_ovf ? TOTAL_L : avail_sum[LW-1:0];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            avail     <= TOTAL_L;
            bitmap    <= '0;
            cnt       <= '0;
            s1_valid  <= 1'b0;
            dup_pulse <= 1'b0;
            bad_pulse <= 1'b0;
        end else begin
            avail    <= avail_next;
            s1_valid <= rel_hit;
            // A hit release and a non-dup apply always address different
            // ids, so the two bit updates never collide.
            if (rel_hit) begin
                bitmap[s_axis_release_id] <= 1'b0;
            end
            if (apply_ok) begin
                bitmap[apply_id] <= 1'b1;
            end
            cnt       <= cnt + {{IW{1'b0}}, apply_ok} - {{IW{1'b0}}, rel_hit};
            dup_pulse <= apply_fire && apply_dup;
            bad_pulse <= rel_miss || avail_ovf;
        end
    end

    // ------------------------------------------------------------------
    // Grant output register: loaded on a non-dup accept, held until taken.
    // apply_ready already guarantees the register is free or draining.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            grant_valid <= 1'b0;
            grant_id    <= '0;
            grant_len   <= '0;
        end else if (apply_ok) begin
            grant_valid <= 1'b1;
            grant_id    <= apply_id;
            grant_len   <= apply_len;
        end else if (m_axis_grant_ready) begin
            grant_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axis_Papply_ready  = apply_ready;
    assign s_axis_release_ready = !sys_rst;
    assign m_axis_grant_valid   = grant_valid;
    assign m_axis_grant_id      = grant_id;
    assign m_axis_grant_len     = grant_len;
    assign source_available     = avail;
    assign outstanding_cnt      = cnt;
    assign err_dup_apply        = dup_pulse;
    assign err_bad_release      = bad_pulse;

endmodule : source_pool_mgr
`default_nettype wire

// File: tb/tb_source_pool_mgr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_source_pool_mgr
//  Purpose  : Directed self-checking bench for source_pool_mgr.
//  Revision : 1.0  initial release
// ============================================================================
module tb_source_pool_mgr;
    import source_pkg::*;

    logic        sys_clk;
    logic        sys_rst;
    logic        apply_valid;
    logic [20:0] apply_id_len;
    logic        apply_ready;
    logic        rel_valid;
    logic [9:0]  rel_id;
    logic        rel_ready;
    logic        grant_valid;
    logic [9:0]  grant_id;
    logic [10:0] grant_len;
    logic        grant_ready;
    logic [10:0] avail;
    logic [10:0] cnt;
    logic        err_dup;
    logic        err_bad;

    int checks;
    int passed;

    source_pool_mgr #(
        .WQE_INDEX_WIDTH   (10),
        .WQE_SOURCE_LENGTH (11),
        .SOURCE_TOTAL      (1024)
    ) dut (
        .sys_clk              (sys_clk),
        .sys_rst              (sys_rst),
        .s_axis_Papply_valid  (apply_valid),
        .s_axis_Papply_id_len (apply_id_len),
        .s_axis_Papply_ready  (apply_ready),
        .s_axis_release_valid (rel_valid),
        .s_axis_release_id    (rel_id),
        .s_axis_release_ready (rel_ready),
        .m_axis_grant_valid   (grant_valid),
        .m_axis_grant_id      (grant_id),
        .m_axis_grant_len     (grant_len),
        .m_axis_grant_ready   (grant_ready),
        .source_available     (avail),
        .outstanding_cnt      (cnt),
        .err_dup_apply        (err_dup),
        .err_bad_release      (err_bad)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and checks happen at +1.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_apply(input logic [9:0] id, input logic [10:0] len);
        apply_valid  = 1'b1;
        apply_id_len = pack_id_len(id, len);
    endtask

    initial begin
        checks       = 0;
        passed       = 0;
        sys_rst      = 1'b1;
        apply_valid  = 1'b0;
        apply_id_len = '0;
        rel_valid    = 1'b0;
        rel_id       = '0;
        grant_ready  = 1'b1;

        // ---------------- reset state ----------------
        drive_apply(10'd1, 11'd1);
        #23;
        chk("rst_apply_ready", apply_ready, 0);
        chk("rst_release_ready", rel_ready, 0);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_grant_len", grant_len, 0);
        chk("rst_avail", avail, 1024);
        chk("rst_cnt", cnt, 0);
        chk("rst_err_dup", err_dup, 0);
        chk("rst_err_bad", err_bad, 0);
        apply_valid = 1'b0;
        sys_rst     = 1'b0;
        step();
        chk("release_ready", rel_ready, 1);

        // ---------------- basic apply {100,5} ----------------
        drive_apply(10'd5, 11'd100);
        #1;
        chk("a5_ready", apply_ready, 1);
        step();
        apply_valid = 1'b0;
        chk("a5_grant_valid", grant_valid, 1);
        chk("a5_grant_id", grant_id, 5);
        chk("a5_grant_len", grant_len, 100);
        chk("a5_avail", avail, 924);
        chk("a5_cnt", cnt, 1);
        step();
        chk("a5_grant_taken", grant_valid, 0);

        // ---------------- release id 5 ----------------
        rel_valid = 1'b1;
        rel_id    = 10'd5;
        step();
        rel_valid = 1'b0;
        chk("r5_err_bad", err_bad, 0);
        chk("r5_cnt", cnt, 0);
        chk("r5_avail_m1", avail, 924);
        step();
        chk("r5_avail_m2", avail, 1024);

        // ---------------- pool exhaustion ----------------
        drive_apply(10'd1, 11'd1000);
        step();
        chk("ex_avail", avail, 24);
        drive_apply(10'd2, 11'd100);
        #1;
        chk("ex_ready_low", apply_ready, 0);
        rel_valid = 1'b1;
        rel_id    = 10'd1;
        step();
        rel_valid = 1'b0;
        chk("ex_ready_m1", apply_ready, 0);
        step();
        chk("ex_avail_m2", avail, 1024);
        chk("ex_ready_m2", apply_ready, 1);
        step();
        apply_valid = 1'b0;
        chk("ex_grant_id", grant_id, 2);
        chk("ex_grant_len", grant_len, 100);
        chk("ex_avail_after", avail, 924);
        rel_valid = 1'b1;
        rel_id    = 10'd2;
        step();
        rel_valid = 1'b0;
        step();
        chk("ex_restored", avail, 1024);

        // ---------------- duplicate apply ----------------
        drive_apply(10'd7, 11'd10);
        step();
        chk("d7_avail", avail, 1014);
        drive_apply(10'd7, 11'd20);
        step();
        apply_valid = 1'b0;
        chk("d7_err_dup", err_dup, 1);
        chk("d7_no_grant", grant_valid, 0);
        chk("d7_avail_same", avail, 1014);
        chk("d7_cnt", cnt, 1);
        step();
        chk("d7_err_dup_clear", err_dup, 0);

        // ---------------- same-cycle apply/release of id 7 ----------------
        drive_apply(10'd7, 11'd20);
        rel_valid = 1'b1;
        rel_id    = 10'd7;
        step();
        apply_valid = 1'b0;
        rel_valid   = 1'b0;
        chk("s7_err_dup", err_dup, 1);
        chk("s7_err_bad", err_bad, 0);
        chk("s7_no_grant", grant_valid, 0);
        chk("s7_cnt", cnt, 0);
        step();
        chk("s7_avail", avail, 1024);

        // ---------------- bad release of id 9 ----------------
        rel_valid = 1'b1;
        rel_id    = 10'd9;
        step();
        rel_valid = 1'b0;
        chk("b9_err_bad", err_bad, 1);
        chk("b9_cnt", cnt, 0);
        step();
        chk("b9_err_clear", err_bad, 0);
        chk("b9_avail", avail, 1024);

        // ---------------- back-pressure ----------------
        grant_ready = 1'b0;
        drive_apply(10'd11, 11'd50);
        step();
        drive_apply(10'd12, 11'd60);
        #1;
        chk("bp_ready_low", apply_ready, 0);
        step();
        step();
        chk("bp_grant_id", grant_id, 11);
        chk("bp_grant_len", grant_len, 50);
        chk("bp_avail_once", avail, 974);
        chk("bp_cnt", cnt, 1);
        grant_ready = 1'b1;
        #1;
        chk("bp_ready_open", apply_ready, 1);
        step();
        drive_apply(10'd13, 11'd70);
        chk("bp_grant2_id", grant_id, 12);
        chk("bp_avail2", avail, 914);
        step();
        apply_valid = 1'b0;
        chk("bp_grant3_id", grant_id, 13);
        chk("bp_avail3", avail, 844);
        chk("bp_cnt3", cnt, 3);

        // ---------------- reset mid-stream ----------------
        grant_ready = 1'b0;
        rel_valid   = 1'b1;
        rel_id      = 10'd12;
        step();
        rel_valid = 1'b0;
        #2;
        sys_rst = 1'b1;
        #1;
        chk("mr_grant_valid", grant_valid, 0);
        chk("mr_grant_id", grant_id, 0);
        chk("mr_grant_len", grant_len, 0);
        chk("mr_avail", avail, 1024);
        chk("mr_cnt", cnt, 0);
        chk("mr_release_ready", rel_ready, 0);
        chk("mr_err_bad", err_bad, 0);
        step();
        sys_rst     = 1'b0;
        grant_ready = 1'b1;
        step();
        chk("mr_avail_after", avail, 1024);
        drive_apply(10'd12, 11'd5);
        step();
        apply_valid = 1'b0;
        chk("mr_no_dup", err_dup, 0);
        chk("mr_regrant", grant_id, 12);
        chk("mr_avail_regrant", avail, 1019);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_source_pool_mgr
`default_nettype wire
